// File: rtl/estacao_reserva.sv
// rtl/estacao_reserva.sv - Tomasulo reservation station with CDB snoop, same-cycle bypass and oldest-first dispatch
module estacao_reserva #(
  parameter int DEPTH    = 3,
  parameter int DATA_W   = 4,
  parameter int TAG_W    = 4,
  parameter int TAG_BASE = 1
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         issue_valid,
  input  logic                         issue_op,
  input  logic [DATA_W-1:0]            issue_vj,
  input  logic [DATA_W-1:0]            issue_vk,
  input  logic [TAG_W-1:0]             issue_qj,
  input  logic [TAG_W-1:0]             issue_qk,
  output logic [TAG_W-1:0]             issue_tag,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  input  logic                         cdb_valid,
  input  logic [TAG_W-1:0]             cdb_tag,
  input  logic [DATA_W-1:0]            cdb_data,
  input  logic                         fu_ready,
  output logic                         fu_start,
  output logic                         fu_op,
  output logic [DATA_W-1:0]            fu_a,
  output logic [DATA_W-1:0]            fu_b,
  output logic [TAG_W-1:0]             fu_tag
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] ST_FREE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;
  localparam logic [1:0] ST_EXEC  = 2'd3;

  logic [1:0]        st_q  [DEPTH];
  logic [1:0]        st_d  [DEPTH];
  logic              op_q  [DEPTH];
  logic              op_d  [DEPTH];
  logic [DATA_W-1:0] vj_q  [DEPTH];
  logic [DATA_W-1:0] vj_d  [DEPTH];
  logic [DATA_W-1:0] vk_q  [DEPTH];
  logic [DATA_W-1:0] vk_d  [DEPTH];
  logic [TAG_W-1:0]  qj_q  [DEPTH];
  logic [TAG_W-1:0]  qj_d  [DEPTH];
  logic [TAG_W-1:0]  qk_q  [DEPTH];
  logic [TAG_W-1:0]  qk_d  [DEPTH];
  logic [AW-1:0]     age_q [DEPTH];
  logic [AW-1:0]     age_d [DEPTH];

  logic              fu_start_q;
  logic              fu_op_q;
  logic [DATA_W-1:0] fu_a_q;
  logic [DATA_W-1:0] fu_b_q;
  logic [TAG_W-1:0]  fu_tag_q;

  logic              free_found;
  logic [AW-1:0]     free_idx;
  logic              sel_found;
  logic [AW-1:0]     sel_idx;
  logic [AW-1:0]     sel_age;
  logic              dispatch;
  logic              accept;
  logic              cdb_hit;
  logic [DATA_W-1:0] in_vj;
  logic [DATA_W-1:0] in_vk;
  logic [TAG_W-1:0]  in_qj;
  logic [TAG_W-1:0]  in_qk;

  assign fu_start = fu_start_q;
  assign fu_op    = fu_op_q;
  assign fu_a     = fu_a_q;
  assign fu_b     = fu_b_q;
  assign fu_tag   = fu_tag_q;

  always_comb begin
    full       = 1'b1;
    count      = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (st_q[i] == ST_FREE) begin
        full = 1'b0;
        if (!free_found) begin
          free_found = 1'b1;
          free_idx   = AW'(i);
        end
      end else begin
        count = count + CW'(1);
      end
    end
    issue_tag = full ? '0 : (TAG_W'(TAG_BASE) + TAG_W'(free_idx));
  end

  // Oldest READY entry wins; strict compare keeps the lowest index on a tie.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_age   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (st_q[i] == ST_READY && (!sel_found || age_q[i] > sel_age)) begin
        sel_found = 1'b1;
        sel_idx   = AW'(i);
        sel_age   = age_q[i];
      end
    end
    dispatch = fu_ready && !fu_start_q && sel_found;
  end

  always_comb begin
    cdb_hit = cdb_valid && (cdb_tag != '0);
    accept  = issue_valid && !full;
    in_vj   = issue_vj;
    in_qj   = issue_qj;
    in_vk   = issue_vk;
    in_qk   = issue_qk;
    if (cdb_hit && issue_qj == cdb_tag) begin
      in_vj = cdb_data;
      in_qj = '0;
    end
    if (cdb_hit && issue_qk == cdb_tag) begin
      in_vk = cdb_data;
      in_qk = '0;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      st_d[i]  = st_q[i];
      op_d[i]  = op_q[i];
      vj_d[i]  = vj_q[i];
      vk_d[i]  = vk_q[i];
      qj_d[i]  = qj_q[i];
      qk_d[i]  = qk_q[i];
      age_d[i] = age_q[i];
      if (st_q[i] == ST_FREE) begin
        if (accept && free_idx == AW'(i)) begin
          op_d[i]  = issue_op;
          vj_d[i]  = in_vj;
          vk_d[i]  = in_vk;
          qj_d[i]  = in_qj;
          qk_d[i]  = in_qk;
          age_d[i] = '0;
          st_d[i]  = (in_qj == '0 && in_qk == '0) ? ST_READY : ST_WAIT;
        end
      end else begin
        if (accept && age_q[i] != AW'(DEPTH-1)) begin
          age_d[i] = age_q[i] + AW'(1);
        end
        if (st_q[i] == ST_WAIT && cdb_hit) begin
          if (qj_q[i] == cdb_tag) begin
            vj_d[i] = cdb_data;
            qj_d[i] = '0;
          end
          if (qk_q[i] == cdb_tag) begin
            vk_d[i] = cdb_data;
            qk_d[i] = '0;
          end
          if (qj_d[i] == '0 && qk_d[i] == '0) begin
            st_d[i] = ST_READY;
          end
        end
        if (st_q[i] == ST_READY && dispatch && sel_idx == AW'(i)) begin
          st_d[i] = ST_EXEC;
        end
        // Our own result on the CDB retires the entry; reuse starts next edge.
        if (st_q[i] == ST_EXEC && cdb_hit && cdb_tag == TAG_W'(TAG_BASE + i)) begin
          st_d[i]  = ST_FREE;
          op_d[i]  = 1'b0;
          vj_d[i]  = '0;
          vk_d[i]  = '0;
          qj_d[i]  = '0;
          qk_d[i]  = '0;
          age_d[i] = '0;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        st_q[i]  <= ST_FREE;
        op_q[i]  <= 1'b0;
        vj_q[i]  <= '0;
        vk_q[i]  <= '0;
        qj_q[i]  <= '0;
        qk_q[i]  <= '0;
        age_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        st_q[i]  <= st_d[i];
        op_q[i]  <= op_d[i];
        vj_q[i]  <= vj_d[i];
        vk_q[i]  <= vk_d[i];
        qj_q[i]  <= qj_d[i];
        qk_q[i]  <= qk_d[i];
        age_q[i] <= age_d[i];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fu_start_q <= 1'b0;
      fu_op_q    <= 1'b0;
      fu_a_q     <= '0;
      fu_b_q     <= '0;
      fu_tag_q   <= '0;
    end else begin
      fu_start_q <= dispatch;
      if (dispatch) begin
        fu_op_q  <= op_q[sel_idx];
        fu_a_q   <= vj_q[sel_idx];
        fu_b_q   <= vk_q[sel_idx];
        fu_tag_q <= TAG_W'(TAG_BASE) + TAG_W'(sel_idx);
      end
    end
  end

endmodule
